data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Handshaked data-memory target that answers load/store requests from a processor datapath's memory stage, replacing the zero-latency data RAM macro when wait states must be modelled. It accepts one request at a time and returns read data or a store acknowledgement after a programmable number of wait states. It checks alignment and applies per-byte write enables. It lets the multicycle and pipelined cores exercise stall logic against a realistic memory end.

Parameters:
ADDR_W, 7, byte-address width; storage = 2^(ADDR_W-2) 32-bit words
WAIT_STATES, 1, extra cycles between acceptance and response, legal range 0..15

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_wren  input  1  1 = store, 0 = load
req_address  input  ADDR_W  byte address, must be word-aligned
req_wdata  input  32  store data
req_byteen  input  4  store byte enables, bit i -> byte i (bits [8i+7:8i])
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  32  load data (0 for stores and errors)
resp_error  output  1  request was misaligned

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE. req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0. Any latched request is dropped; an uncommitted store is not performed.
- Memory contents are not reset. They persist across reset and hold whatever was last written.
- req_ready is registered. It is 1 only in IDLE, and becomes 1 on the first clock edge after reset_n deasserts.
- Acceptance: req_valid && req_ready at a rising edge (edge A). At edge A, latch req_wren, req_address, req_wdata and req_byteen. Inputs are ignored at all other times.
- States:
  - IDLE: on acceptance, go to WAIT if WAIT_STATES>0 and load counter with WAIT_STATES-1. If WAIT_STATES=0, go directly to RESP.
  - WAIT: decrement the counter each edge. When the counter is 0, the next edge goes to RESP.
  - RESP: resp_valid=1. On resp_valid && resp_ready, go to IDLE; resp_valid drops and req_ready rises after that edge.
- Latency: resp_valid first asserts in the cycle after edge A+WAIT_STATES. With WAIT_STATES=0 that is the cycle immediately after edge A.
- Minimum request spacing is WAIT_STATES+2 cycles when resp_ready is held at 1.
- Commit: the edge that enters RESP also performs the operation.
  - Load: resp_rdata = mem[addr[ADDR_W-1:2]].
  - Store: for each i with byteen[i]=1, byte i of the word is overwritten. resp_rdata=0.
- A load issued after a store returns the stored data; there is no hazard, because only one request is outstanding.
- Misaligned request (addr[1:0]!=0): resp_error=1, resp_rdata=0, no memory change. Timing is identical to the normal case.
- A store with byteen=4'b0000 leaves memory unchanged, resp_error=0, and is still acknowledged normally.
- While resp_valid=1 and resp_ready=0, resp_rdata and resp_error hold stable. resp_valid stays 1 with no timeout.
- resp_rdata and resp_error are cleared to 0 on the RESP->IDLE edge.
- Address width: addr[ADDR_W-1:2] indexes the whole array, so there is no out-of-range case.
- Reset asserted during WAIT: the store is lost. Reset asserted during RESP: the store is already committed and the response is lost.

Test Plan:
1. Reset, then WAIT_STATES=1. Store addr 0x08, wdata 0xDEADBEEF, byteen 4'hF. Then load 0x08. Required: each resp_valid appears 2 cycles after acceptance; the load returns 0xDEADBEEF with resp_error=0.
2. Starting from word 0x08 = 0xDEADBEEF, store 0x000000AA with byteen 4'b0001, then 0x0000BB00 with byteen 4'b0010. A load of 0x08 returns 0xDEADBBAA.
3. Load addr 0x0A (misaligned). Required: resp_error=1 and resp_rdata=0. A misaligned store to 0x09 leaves word 0x08 unchanged on re-read.
4. Hold resp_ready=0 for 5 cycles during a load response. Required: resp_valid, resp_rdata and resp_error stay stable and req_ready=0 throughout. After resp_ready=1, req_ready=1 on the following cycle.
5. Build with WAIT_STATES=0, keep req_valid and resp_ready held at 1, and issue 4 back-to-back loads. Required: one response every 2 cycles, in order, with correct data.
6. Build with WAIT_STATES=3. Pull reset_n low during WAIT of a store to 0x10 with data 0x12345678. Required: outputs go to 0 immediately, and after reset a load of 0x10 returns the old value.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Request/response bus between a memory-stage initiator and the data-memory responder.
// One request is outstanding at a time; both channels use valid/ready handshakes.
interface data_memory_responder_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_address;
    logic [31:0]       req_wdata;
    logic [3:0]        req_byteen;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_error;

    modport master (
        output req_valid,
        output req_wren,
        output req_address,
        output req_wdata,
        output req_byteen,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_error
    );

    modport slave (
        input  req_valid,
        input  req_wren,
        input  req_address,
        input  req_wdata,
        input  req_byteen,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised data memory behind a valid/ready handshake with programmable wait states.
// Checks word alignment, applies byte enables and returns one response per accepted request.
module data_memory_responder #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    data_memory_responder_if.slave bus
);

    localparam int unsigned Depth    = 2 ** (ADDR_W - 2);
    localparam int unsigned WaitInit = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WaitLoad = 4'(WaitInit);
    localparam bit          NoWait   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_error_q;
    logic [31:0]       resp_rdata_q;
    logic [3:0]        cnt_q;

    logic              wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        byteen_q;

    logic [31:0]       mem [Depth];

    logic              accept;
    logic              commit;
    logic              op_wren;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [3:0]        op_byteen;
    logic [ADDR_W-3:0] op_idx;
    logic              op_misaligned;
    logic [31:0]       load_data;

    // Zero-wait commits straight from the bus at acceptance; otherwise from the latched copy.
    always_comb begin
        accept = bus.req_valid && req_ready_q;
        if (state_q == StIdle) begin
            op_wren   = bus.req_wren;
            op_addr   = bus.req_address;
            op_wdata  = bus.req_wdata;
            op_byteen = bus.req_byteen;
        end else begin
            op_wren   = wren_q;
            op_addr   = addr_q;
            op_wdata  = wdata_q;
            op_byteen = byteen_q;
        end
        op_idx        = op_addr[ADDR_W-1:2];
        op_misaligned = |op_addr[1:0];
        load_data     = (op_wren || op_misaligned) ? 32'h0 : mem[op_idx];
        commit        = (state_q == StIdle && accept && NoWait) ||
                        (state_q == StWait && cnt_q == 4'd0);
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (commit && op_wren && !op_misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (op_byteen[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            cnt_q        <= 4'd0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            byteen_q     <= 4'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        wren_q      <= bus.req_wren;
                        addr_q      <= bus.req_address;
                        wdata_q     <= bus.req_wdata;
                        byteen_q    <= bus.req_byteen;
                        req_ready_q <= 1'b0;
                        if (NoWait) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= load_data;
                            resp_error_q <= op_misaligned;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitLoad;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                        resp_error_q <= op_misaligned;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        resp_error_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three builds (1, 0 and 3 wait states) sharing request stimulus,
// with expected responses queued at acceptance and checked when each response appears.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wren = 1'b0;
    logic [6:0]  req_address = 7'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_byteen = 4'h0;
    logic        resp_ready = 1'b1;
    int          sel = 0;

    logic        obs_req_ready;
    logic        obs_resp_valid;
    logic [31:0] obs_resp_rdata;
    logic        obs_resp_error;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    data_memory_responder_if #(.ADDR_W(7)) bus_ws1 ();
    data_memory_responder_if #(.ADDR_W(7)) bus_ws0 ();
    data_memory_responder_if #(.ADDR_W(7)) bus_ws3 ();

    assign bus_ws1.req_valid   = req_valid && (sel == 0);
    assign bus_ws1.req_wren    = req_wren;
    assign bus_ws1.req_address = req_address;
    assign bus_ws1.req_wdata   = req_wdata;
    assign bus_ws1.req_byteen  = req_byteen;
    assign bus_ws1.resp_ready  = resp_ready;

    assign bus_ws0.req_valid   = req_valid && (sel == 1);
    assign bus_ws0.req_wren    = req_wren;
    assign bus_ws0.req_address = req_address;
    assign bus_ws0.req_wdata   = req_wdata;
    assign bus_ws0.req_byteen  = req_byteen;
    assign bus_ws0.resp_ready  = resp_ready;

    assign bus_ws3.req_valid   = req_valid && (sel == 2);
    assign bus_ws3.req_wren    = req_wren;
    assign bus_ws3.req_address = req_address;
    assign bus_ws3.req_wdata   = req_wdata;
    assign bus_ws3.req_byteen  = req_byteen;
    assign bus_ws3.resp_ready  = resp_ready;

    data_memory_responder #(.ADDR_W(7), .WAIT_STATES(1)) u_ws1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_ws1)
    );

    data_memory_responder #(.ADDR_W(7), .WAIT_STATES(0)) u_ws0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_ws0)
    );

    data_memory_responder #(.ADDR_W(7), .WAIT_STATES(3)) u_ws3 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_ws3)
    );

    always_comb begin
        obs_req_ready  = 1'b0;
        obs_resp_valid = 1'b0;
        obs_resp_rdata = 32'h0;
        obs_resp_error = 1'b0;
        case (sel)
            0: begin
                obs_req_ready  = bus_ws1.req_ready;
                obs_resp_valid = bus_ws1.resp_valid;
                obs_resp_rdata = bus_ws1.resp_rdata;
                obs_resp_error = bus_ws1.resp_error;
            end
            1: begin
                obs_req_ready  = bus_ws0.req_ready;
                obs_resp_valid = bus_ws0.resp_valid;
                obs_resp_rdata = bus_ws0.resp_rdata;
                obs_resp_error = bus_ws0.resp_error;
            end
            default: begin
                obs_req_ready  = bus_ws3.req_ready;
                obs_resp_valid = bus_ws3.resp_valid;
                obs_resp_rdata = bus_ws3.resp_rdata;
                obs_resp_error = bus_ws3.resp_error;
            end
        endcase
    end

    // Drive one request on the selected build, wait for acceptance, then check latency and response.
    task automatic send_request(input logic wren, input logic [6:0] addr, input logic [31:0] wdata,
                                input logic [3:0] byteen, input string name, output bit accepted);
        bit rdy;
        @(negedge clock);
        req_wren    = wren;
        req_address = addr;
        req_wdata   = wdata;
        req_byteen  = byteen;
        req_valid   = 1'b1;
        accepted    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rdy = obs_req_ready;
            @(posedge clock);
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1 req_valid = 1'b0;
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL %s accept: req_ready never seen within 20 cycles, required acceptance", name);
        end
    endtask

    task automatic transact(input logic wren, input logic [6:0] addr, input logic [31:0] wdata,
                            input logic [3:0] byteen, input logic [31:0] exp_rdata, input logic exp_err,
                            input int exp_lat, input int hold, input string name);
        exp_t e;
        int   lat;
        bit   accepted;
        bit   got;
        resp_ready = (hold == 0);
        send_request(wren, addr, wdata, byteen, name, accepted);
        if (!accepted) begin
            resp_ready = 1'b1;
            return;
        end
        e.rdata = exp_rdata;
        e.error = exp_err;
        sb.push_back(e);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (obs_resp_valid) got = 1'b1;
        end
        vectors++;
        if (!got || lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles (valid seen=%0d), required %0d", name, lat, got,
                     exp_lat);
        end
        if (!got) begin
            void'(sb.pop_front());
            resp_ready = 1'b1;
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (obs_resp_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL %s rdata: got %h, required %h", name, obs_resp_rdata, e.rdata);
        end
        vectors++;
        if (obs_resp_error !== e.error) begin
            miscompares++;
            $display("FAIL %s error: got %b, required %b", name, obs_resp_error, e.error);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            vectors++;
            if ({obs_resp_valid, obs_req_ready, obs_resp_error, obs_resp_rdata} !==
                {1'b1, 1'b0, e.error, e.rdata}) begin
                miscompares++;
                $display("FAIL %s hold%0d: got valid=%b ready=%b err=%b rdata=%h, required 1 0 %b %h",
                         name, k, obs_resp_valid, obs_req_ready, obs_resp_error, obs_resp_rdata,
                         e.error, e.rdata);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({obs_resp_valid, obs_req_ready, obs_resp_error, obs_resp_rdata} !==
            {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL %s release: got valid=%b ready=%b err=%b rdata=%h, required 0 1 0 0",
                     name, obs_resp_valid, obs_req_ready, obs_resp_error, obs_resp_rdata);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            vectors++;
            if ({obs_req_ready, obs_resp_valid, obs_resp_error, obs_resp_rdata} !== 35'h0) begin
                miscompares++;
                $display("FAIL reset_outputs[%0d]: got ready=%b valid=%b err=%b rdata=%h, required 0",
                         s, obs_req_ready, obs_resp_valid, obs_resp_error, obs_resp_rdata);
            end
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({bus_ws1.req_ready, bus_ws0.req_ready, bus_ws3.req_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ready_early: got %b, required 000",
                     {bus_ws1.req_ready, bus_ws0.req_ready, bus_ws3.req_ready});
        end
        @(negedge clock);
        vectors++;
        if ({bus_ws1.req_ready, bus_ws0.req_ready, bus_ws3.req_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready_rise: got %b, required 111",
                     {bus_ws1.req_ready, bus_ws0.req_ready, bus_ws3.req_ready});
        end
    endtask

    task automatic test_store_load();
        sel = 0;
        transact(1'b1, 7'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 0, "t1_store");
        transact(1'b0, 7'h08, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2, 0, "t1_load");
    endtask

    task automatic test_byte_enables();
        sel = 0;
        transact(1'b1, 7'h08, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 2, 0, "t2_store_b0");
        transact(1'b1, 7'h08, 32'h0000BB00, 4'b0010, 32'h0, 1'b0, 2, 0, "t2_store_b1");
        transact(1'b0, 7'h08, 32'h0, 4'h0, 32'hDEADBBAA, 1'b0, 2, 0, "t2_load");
        transact(1'b1, 7'h08, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 2, 0, "t2_store_none");
        transact(1'b0, 7'h08, 32'h0, 4'h0, 32'hDEADBBAA, 1'b0, 2, 0, "t2_load_none");
    endtask

    task automatic test_misaligned();
        sel = 0;
        transact(1'b0, 7'h0A, 32'h0, 4'h0, 32'h0, 1'b1, 2, 0, "t3_load_mis");
        transact(1'b1, 7'h09, 32'h11111111, 4'hF, 32'h0, 1'b1, 2, 0, "t3_store_mis");
        transact(1'b0, 7'h08, 32'h0, 4'h0, 32'hDEADBBAA, 1'b0, 2, 0, "t3_reread");
    endtask

    task automatic test_backpressure();
        sel = 0;
        transact(1'b0, 7'h08, 32'h0, 4'h0, 32'hDEADBBAA, 1'b0, 2, 5, "t4_hold");
    endtask

    task automatic test_back_to_back();
        logic [6:0]  addrs [4];
        logic [31:0] vals [4];
        exp_t        e;
        int          issued;
        int          got;
        int          last;
        bit          rdy;
        addrs[0] = 7'h00; vals[0] = 32'h0BAD0001;
        addrs[1] = 7'h04; vals[1] = 32'h1234ABCD;
        addrs[2] = 7'h0C; vals[2] = 32'h55AA33CC;
        addrs[3] = 7'h14; vals[3] = 32'hF00DFACE;
        sel = 1;
        for (int i = 0; i < 4; i++) begin
            transact(1'b1, addrs[i], vals[i], 4'hF, 32'h0, 1'b0, 1, 0, "t5_preload");
        end
        @(negedge clock);
        resp_ready  = 1'b1;
        req_wren    = 1'b0;
        req_byteen  = 4'h0;
        req_address = addrs[0];
        req_valid   = 1'b1;
        issued = 0;
        got    = 0;
        last   = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            rdy = obs_req_ready;
            if (obs_resp_valid && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (obs_resp_rdata !== e.rdata || obs_resp_error !== e.error) begin
                    miscompares++;
                    $display("FAIL t5_b2b_data%0d: got %h err=%b, required %h err=%b", got,
                             obs_resp_rdata, obs_resp_error, e.rdata, e.error);
                end
                if (got > 0) begin
                    vectors++;
                    if (cyc - last != 2) begin
                        miscompares++;
                        $display("FAIL t5_b2b_spacing%0d: got %0d cycles, required 2", got,
                                 cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            @(posedge clock);
            if (rdy && req_valid) begin
                e.rdata = vals[issued];
                e.error = 1'b0;
                sb.push_back(e);
                issued++;
            end
            @(negedge clock);
            if (issued < 4) req_address = addrs[issued];
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("FAIL t5_b2b_count: got %0d responses, required 4", got);
        end
        sb.delete();
    endtask

    task automatic test_reset_in_wait();
        bit accepted;
        sel = 2;
        transact(1'b1, 7'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 4, 0, "t6_old");
        send_request(1'b1, 7'h10, 32'h12345678, 4'hF, "t6_store", accepted);
        if (!accepted) return;
        @(negedge clock);
        vectors++;
        if (obs_resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_in_wait: got resp_valid=%b, required 0", obs_resp_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({obs_req_ready, obs_resp_valid, obs_resp_error, obs_resp_rdata} !== 35'h0) begin
            miscompares++;
            $display("FAIL t6_reset_outputs: got ready=%b valid=%b err=%b rdata=%h, required 0",
                     obs_req_ready, obs_resp_valid, obs_resp_error, obs_resp_rdata);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        transact(1'b0, 7'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 4, 0, "t6_load_old");
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
